// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared state encoding and default widths for the sum accumulator
package sum_acc_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int SUM_W_DEF = 4;
    localparam int ACC_W_DEF = 8;
endpackage

// File: rtl/sum_acc_ctrl.sv
// sum_acc_ctrl: batch FSM and counter driving handshakes and datapath strobes
module sum_acc_ctrl
    import sum_acc_pkg::*;
#(
    parameter int BATCH_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load,
    output logic add,
    output logic clear
);
    localparam logic [CNT_W:0] LAST_CNT = (CNT_W+1)'(BATCH_LEN - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic accept, last, drain;
    always_comb begin
        accept  = in_valid & in_ready & ~clr;
        last    = accept & ({1'b0, cnt} == LAST_CNT);
        drain   = (state == DONE) & out_ready;
        load    = accept & (state == IDLE);
        add     = accept & (state == ACCUM);
        clear   = clr | drain;
        state_n = clr ? IDLE : last ? DONE : accept ? ACCUM : drain ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= clear ? '0 : accept ? cnt + CNT_W'(1) : cnt;
            in_ready  <= state_n != DONE;
            out_valid <= state_n == DONE;
        end
    end
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: batches adder sums into a total with sticky overflow; ACC_SATURATE_EN clamps instead of wrapping
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SUM_W     = SUM_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int BATCH_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    logic load, add, clear, carry, ovf;
    logic [ACC_W:0] sum;
    logic [ACC_W-1:0] acc, acc_n;
    sum_acc_ctrl #(.BATCH_LEN(BATCH_LEN), .CNT_W(CNT_W)) u_ctrl (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .in_valid(in_valid),
        .out_ready(out_ready),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .load(load),
        .add(add),
        .clear(clear)
    );
    always_comb begin
        sum   = {1'b0, load ? ACC_W'(0) : acc} + (ACC_W+1)'(in_sum);
        carry = sum[ACC_W];
`ifdef ACC_SATURATE_EN
        acc_n = (carry | ovf) ? '1 : sum[ACC_W-1:0];
`else
        acc_n = sum[ACC_W-1:0];
`endif
    end
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (load || add) begin
            acc <= acc_n;
            ovf <= ovf | carry;
        end
    end
    assign out_acc = acc;
    assign out_ovf = ovf;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed checks of batching, backpressure, clr, rst, overflow and BATCH_LEN=1
module tb_sum_accumulator;
`ifdef ACC_SATURATE_EN
    localparam logic [5:0] W6_EXP = 6'h3F;
`else
    localparam logic [5:0] W6_EXP = 6'h30;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] in_sum = '0;
    logic b1_valid = 1'b0, b1_out_ready = 1'b0;
    logic [3:0] b1_sum = '0;
    logic m_in_ready, m_out_valid, m_out_ovf;
    logic [7:0] m_out_acc;
    logic w_in_ready, w_out_valid, w_out_ovf;
    logic [5:0] w_out_acc;
    logic b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0] b_out_acc;
    logic [3:0] vec1 [8] = '{4'd0, 4'd6, 4'd4, 4'd4, 4'd4, 4'd8, 4'd13, 4'd11};
    logic [3:0] vec6 [4] = '{4'd3, 4'd9, 4'd15, 4'd0};
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    sum_accumulator u_main (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_sum(in_sum), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_acc(m_out_acc), .out_ovf(m_out_ovf)
    );
    sum_accumulator #(.ACC_W(6)) u_w6 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_sum(in_sum), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_acc(w_out_acc), .out_ovf(w_out_ovf)
    );
    sum_accumulator #(.BATCH_LEN(1)) u_b1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(b1_valid), .in_ready(b_in_ready),
        .in_sum(b1_sum), .out_valid(b_out_valid), .out_ready(b1_out_ready),
        .out_acc(b_out_acc), .out_ovf(b_out_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [3:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        tick;
    endtask

    initial begin
        tick;
        chk("rst_in_ready", 32'(m_in_ready), 0);
        chk("rst_out_valid", 32'(m_out_valid), 0);
        chk("rst_out_acc", 32'(m_out_acc), 0);
        chk("rst_out_ovf", 32'(m_out_ovf), 0);
        rst = 1'b0;
        tick;
        chk("post_rst_in_ready", 32'(m_in_ready), 1);
        chk("post_rst_b1_in_ready", 32'(b_in_ready), 1);

        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) feed(vec1[i]);
        chk("t1_no_early_valid", 32'(m_out_valid), 0);
        feed(vec1[7]);
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(m_out_valid), 1);
        chk("t1_out_acc", 32'(m_out_acc), 32'h32);
        chk("t1_out_ovf", 32'(m_out_ovf), 0);
        chk("t1_in_ready_done", 32'(m_in_ready), 0);
        chk("t1_w6_acc", 32'(w_out_acc), 32'h32);
        tick;
        chk("t1_idle_valid", 32'(m_out_valid), 0);
        chk("t1_idle_acc", 32'(m_out_acc), 0);
        chk("t1_idle_in_ready", 32'(m_in_ready), 1);

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(vec1[i]);
        in_sum = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t3_hold_in_ready", 32'(m_in_ready), 0);
            chk("t3_hold_valid", 32'(m_out_valid), 1);
            chk("t3_hold_acc", 32'(m_out_acc), 32'h32);
        end
        out_ready = 1'b1;
        tick;
        chk("t3_release_valid", 32'(m_out_valid), 0);
        chk("t3_release_acc", 32'(m_out_acc), 0);
        tick;
        chk("t3_next_from_zero", 32'(m_out_acc), 5);
        in_valid = 1'b0;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clr_flush_acc", 32'(m_out_acc), 0);

        for (int i = 0; i < 3; i++) feed(4'd3);
        chk("t4_partial", 32'(m_out_acc), 9);
        clr = 1'b1;
        feed(4'd3);
        clr = 1'b0;
        chk("t4_clr_acc", 32'(m_out_acc), 0);
        chk("t4_clr_valid", 32'(m_out_valid), 0);
        chk("t4_clr_in_ready", 32'(m_in_ready), 1);
        for (int i = 0; i < 7; i++) feed(4'd1);
        chk("t4_no_early_valid", 32'(m_out_valid), 0);
        feed(4'd1);
        in_valid = 1'b0;
        chk("t4_out_valid", 32'(m_out_valid), 1);
        chk("t4_out_acc", 32'(m_out_acc), 8);
        tick;

        for (int i = 0; i < 8; i++) feed(4'd14);
        in_valid = 1'b0;
        chk("t2_w6_valid", 32'(w_out_valid), 1);
        chk("t2_w6_acc", 32'(w_out_acc), 32'(W6_EXP));
        chk("t2_w6_ovf", 32'(w_out_ovf), 1);
        chk("t2_main_acc", 32'(m_out_acc), 32'h70);
        chk("t2_main_ovf", 32'(m_out_ovf), 0);
        tick;
        chk("t2_w6_ovf_cleared", 32'(w_out_ovf), 0);

        for (int i = 0; i < 3; i++) feed(4'd7);
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_in_ready", 32'(m_in_ready), 0);
        chk("t5_valid", 32'(m_out_valid), 0);
        chk("t5_acc", 32'(m_out_acc), 0);
        chk("t5_ovf", 32'(m_out_ovf), 0);
        tick;
        for (int i = 0; i < 8; i++) feed(4'd2);
        in_valid = 1'b0;
        chk("t5_out_valid", 32'(m_out_valid), 1);
        chk("t5_out_acc", 32'(m_out_acc), 16);
        tick;

        b1_valid = 1'b1;
        b1_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b1_sum = vec6[i];
            tick;
            chk("t6_valid", 32'(b_out_valid), 1);
            chk("t6_acc", 32'(b_out_acc), 32'(vec6[i]));
            chk("t6_in_ready_done", 32'(b_in_ready), 0);
            tick;
            chk("t6_idle_valid", 32'(b_out_valid), 0);
            chk("t6_idle_in_ready", 32'(b_in_ready), 1);
        end
        b1_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
